// File: rtl/pulse_width_meter_if.sv
// +----------------------------------------------------------------------------+
// | Module : pulse_width_meter_if                                              |
// | Brief  : Result handshake bundle of the pulse width meter.                 |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pulse_width_meter_if #(
    parameter int CNT_W = 8
);
    logic             meas_valid;
    logic             meas_ready;
    logic [CNT_W-1:0] meas_width;
    logic             meas_glitch;
    logic             meas_sat;

    modport master (
        output meas_valid,
        output meas_width,
        output meas_glitch,
        output meas_sat,
        input  meas_ready
    );

    modport slave (
        input  meas_valid,
        input  meas_width,
        input  meas_glitch,
        input  meas_sat,
        output meas_ready
    );
endinterface

`default_nettype wire

// File: rtl/pulse_width_meter.sv
// +----------------------------------------------------------------------------+
// | Module : pulse_width_meter                                                 |
// | Brief  : Measures the high time of a synchronised level input in clocks    |
// |          and holds the result until a valid/ready handshake.               |
// |          Optional macro PULSE_WIDTH_METER_DROP_CNT_EN adds drop_cnt.       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pulse_width_meter #(
    parameter int CNT_W = 8,
    parameter int MIN_W = 3
) (
    input  wire logic               clock,
    input  wire logic               reset,
    input  wire logic               din,
    pulse_width_meter_if.master     meas,
    output logic                    busy
`ifdef PULSE_WIDTH_METER_DROP_CNT_EN
    ,
    output logic [7:0]              drop_cnt
`endif
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_measure = 2'd1;
    localparam logic [1:0] c_st_hold    = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W:0]   c_min_w   = (CNT_W+1)'(MIN_W);

    logic             r_s1;
    logic             r_s2;
    logic             r_prev;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic             r_sat;
    logic [CNT_W-1:0] r_width;
    logic             r_glitch;
    logic             r_res_sat;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_rise;
    logic             w_fall;
    logic             w_hs;
    logic             w_start;

    // Synchroniser resets high so a level already high at release is never seen as an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_s1   <= din;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign w_rise  = r_s2 & ~r_prev;
    assign w_fall  = ~r_s2 & r_prev;
    assign w_hs    = (r_state == c_st_hold) & meas.meas_ready;
    assign w_start = w_rise & ((r_state == c_st_idle) | w_hs);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_rise) begin
                    w_state_nxt = c_st_measure;
                end
            end
            c_st_measure: begin
                if (w_fall) begin
                    w_state_nxt = c_st_hold;
                end
            end
            c_st_hold: begin
                // A rise without handshake is dropped: the state stays in HOLD.
                if (w_hs) begin
                    w_state_nxt = w_rise ? c_st_measure : c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_comb begin
        busy             = (r_state == c_st_measure);
        meas.meas_valid  = (r_state == c_st_hold);
        meas.meas_width  = r_width;
        meas.meas_glitch = r_glitch;
        meas.meas_sat    = r_res_sat;
    end

    assign w_count_inc = (r_count == c_cnt_max) ? r_count : (r_count + c_cnt_one);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count   <= '0;
            r_sat     <= 1'b0;
            r_width   <= '0;
            r_glitch  <= 1'b0;
            r_res_sat <= 1'b0;
        end else begin
            if (w_start) begin
                r_count <= c_cnt_one;
                r_sat   <= (c_cnt_one == c_cnt_max);
            end else if ((r_state == c_st_measure) && r_s2) begin
                r_count <= w_count_inc;
                r_sat   <= r_sat | (w_count_inc == c_cnt_max);
            end
            if ((r_state == c_st_measure) && w_fall) begin
                r_width   <= r_count;
                r_glitch  <= ({1'b0, r_count} < c_min_w);
                r_res_sat <= r_sat;
            end
        end
    end

`ifdef PULSE_WIDTH_METER_DROP_CNT_EN
    logic [7:0] r_drop_cnt;
    logic       w_drop;

    assign w_drop = (r_state == c_st_hold) & w_rise & ~meas.meas_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pulse_width_meter.sv
// +----------------------------------------------------------------------------+
// | Module : tb_pulse_width_meter                                              |
// | Brief  : Self-checking bench for pulse_width_meter (CNT_W 8 and 4).        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_pulse_width_meter;

    localparam int MIN_W = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic din   = 1'b0;
    logic ready = 1'b0;
    logic busy8;
    logic busy4;

    always #5 clock = ~clock;

    pulse_width_meter_if #(.CNT_W(8)) if8 ();
    pulse_width_meter_if #(.CNT_W(4)) if4 ();
    assign if8.meas_ready = ready;
    assign if4.meas_ready = ready;

`ifdef PULSE_WIDTH_METER_DROP_CNT_EN
    logic [7:0] drop8;
    logic [7:0] drop4;
`endif

    pulse_width_meter #(.CNT_W(8), .MIN_W(MIN_W)) u_dut8 (
        .clock    (clock),
        .reset    (reset),
        .din      (din),
        .meas     (if8.master),
        .busy     (busy8)
`ifdef PULSE_WIDTH_METER_DROP_CNT_EN
        ,
        .drop_cnt (drop8)
`endif
    );

    pulse_width_meter #(.CNT_W(4), .MIN_W(MIN_W)) u_dut4 (
        .clock    (clock),
        .reset    (reset),
        .din      (din),
        .meas     (if4.master),
        .busy     (busy4)
`ifdef PULSE_WIDTH_METER_DROP_CNT_EN
        ,
        .drop_cnt (drop4)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference: din delayed by edges; a pulse of N samples gives width min(N, max).
    int m_mode;     // 0 idle, 1 measuring, 2 holding
    int m_e;
    int m_rise_e;
    bit h1, h2, h3;
    int m_w8, m_w4, m_drop;
    bit m_g8, m_g4, m_s8, m_s4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rise, fall, hs;
        int n;
        rise = h2 && !h3;
        fall = !h2 && h3;
        hs   = (m_mode == 2) && ready;
        if (reset) begin
            m_mode = 0; m_w8 = 0; m_w4 = 0; m_g8 = 0; m_g4 = 0;
            m_s8 = 0; m_s4 = 0; m_drop = 0;
            h1 = 1; h2 = 1; h3 = 1;
        end else begin
            case (m_mode)
                0: if (rise) begin m_mode = 1; m_rise_e = m_e; end
                1: if (fall) begin
                    n    = m_e - m_rise_e;
                    m_w8 = (n > 255) ? 255 : n;
                    m_w4 = (n > 15) ? 15 : n;
                    m_s8 = (n >= 255);
                    m_s4 = (n >= 15);
                    m_g8 = (m_w8 < MIN_W);
                    m_g4 = (m_w4 < MIN_W);
                    m_mode = 2;
                end
                default: begin
                    if (hs) begin
                        if (rise) begin m_mode = 1; m_rise_e = m_e; end
                        else m_mode = 0;
                    end else if (rise) begin
                        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                    end
                end
            endcase
            h3 = h2; h2 = h1; h1 = din;
        end
        m_e++;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        chk("valid8",  if8.meas_valid,  (m_mode == 2));
        chk("busy8",   busy8,           (m_mode == 1));
        chk("width8",  if8.meas_width,  m_w8);
        chk("glitch8", if8.meas_glitch, m_g8);
        chk("sat8",    if8.meas_sat,    m_s8);
        chk("valid4",  if4.meas_valid,  (m_mode == 2));
        chk("busy4",   busy4,           (m_mode == 1));
        chk("width4",  if4.meas_width,  m_w4);
        chk("glitch4", if4.meas_glitch, m_g4);
        chk("sat4",    if4.meas_sat,    m_s4);
`ifdef PULSE_WIDTH_METER_DROP_CNT_EN
        chk("drop8",   drop8,           m_drop);
        chk("drop4",   drop4,           m_drop);
`endif
    endtask

    task automatic wait_valid(input string name);
        int t;
        t = 0;
        while (if8.meas_valid !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        chk(name, if8.meas_valid, 1);
    endtask

    typedef struct {
        int len;
        int w8; bit g8; bit s8;
        int w4; bit g4; bit s4;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{5,   5,   0, 0, 5,  0, 0};
        tbl[1] = '{2,   2,   1, 0, 2,  1, 0};
        tbl[2] = '{20,  20,  0, 0, 15, 0, 1};
        tbl[3] = '{1,   1,   1, 0, 1,  1, 0};
        tbl[4] = '{3,   3,   0, 0, 3,  0, 0};
        tbl[5] = '{15,  15,  0, 0, 15, 0, 1};
        tbl[6] = '{14,  14,  0, 0, 14, 0, 0};
        tbl[7] = '{300, 255, 0, 1, 15, 0, 1};

        // Reset state
        reset = 1; din = 0; ready = 0;
        tick(); tick();
        chk("rst_valid", if8.meas_valid, 0);
        chk("rst_busy",  busy8, 0);
        chk("rst_width", if8.meas_width, 0);
        reset = 0;

        // 5-clock pulse: valid two clocks after first low sample, for one cycle
        ready = 1; din = 0;
        repeat (4) tick();
        din = 1;
        repeat (5) tick();
        din = 0;
        tick(); chk("lat_v_k5", if8.meas_valid, 0);
        tick(); chk("lat_v_k6", if8.meas_valid, 0);
        tick(); chk("lat_v_k7", if8.meas_valid, 1);
        chk("lat_width", if8.meas_width, 5);
        chk("lat_glitch", if8.meas_glitch, 0);
        chk("lat_sat", if8.meas_sat, 0);
        tick(); chk("lat_v_k8", if8.meas_valid, 0);

        // Table of pulse lengths
        for (int i = 0; i < 8; i++) begin
            ready = 1; din = 0;
            repeat (4) tick();
            din = 1;
            repeat (tbl[i].len) tick();
            din = 0;
            wait_valid("tbl_valid");
            chk("tbl_w8", if8.meas_width,  tbl[i].w8);
            chk("tbl_g8", if8.meas_glitch, tbl[i].g8);
            chk("tbl_s8", if8.meas_sat,    tbl[i].s8);
            chk("tbl_w4", if4.meas_width,  tbl[i].w4);
            chk("tbl_g4", if4.meas_glitch, tbl[i].g4);
            chk("tbl_s4", if4.meas_sat,    tbl[i].s4);
        end

        // Held result, second pulse dropped, then handshake
        reset = 1; tick(); reset = 0;
        ready = 0; din = 0;
        repeat (4) tick();
        din = 1; repeat (4) tick();
        din = 0; repeat (4) tick();
        din = 1; repeat (6) tick();
        din = 0; repeat (6) tick();
        chk("hold_valid", if8.meas_valid, 1);
        chk("hold_width", if8.meas_width, 4);
        chk("hold_busy",  busy8, 0);
`ifdef PULSE_WIDTH_METER_DROP_CNT_EN
        chk("hold_drop",  drop8, 1);
`endif
        ready = 1;
        tick();
        chk("hold_rel_valid", if8.meas_valid, 0);
        chk("hold_rel_busy",  busy8, 0);
        repeat (4) tick();
        chk("hold_no_remeas", if8.meas_valid, 0);

        // din already high at reset release
        reset = 1; din = 1;
        repeat (2) tick();
        reset = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hi_at_rst_valid", if8.meas_valid, 0);
            chk("hi_at_rst_busy",  busy8, 0);
        end
        din = 0; repeat (3) tick();
        din = 1; repeat (3) tick();
        din = 0;
        wait_valid("after_rst_valid");
        chk("after_rst_width", if8.meas_width, 3);

        // Reset in the middle of a pulse
        ready = 1; din = 0;
        repeat (4) tick();
        din = 1; repeat (4) tick();
        chk("abort_busy_pre", busy8, 1);
        reset = 1; tick();
        chk("abort_busy",   busy8, 0);
        chk("abort_valid",  if8.meas_valid, 0);
        chk("abort_width",  if8.meas_width, 0);
        chk("abort_glitch", if8.meas_glitch, 0);
        chk("abort_sat",    if8.meas_sat, 0);
        reset = 0;
        repeat (3) tick();
        din = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_no_result", if8.meas_valid, 0);
        end

        // Random pulses, random ready, occasional reset
        for (int p = 0; p < 150; p++) begin
            int hi, lo;
            hi = $urandom_range(1, 24);
            lo = $urandom_range(1, 8);
            din = 1;
            for (int c = 0; c < hi; c++) begin
                ready = ($urandom_range(0, 2) != 0);
                tick();
            end
            din = 0;
            for (int c = 0; c < lo; c++) begin
                ready = ($urandom_range(0, 2) != 0);
                tick();
            end
            if ($urandom_range(0, 29) == 0) begin
                reset = 1; tick(); reset = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pulse_width_meter.md
PULSE_WIDTH_METER -- requirements
Module: pulse_width_meter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width counter and result width in bits.
REQ-002 The block SHALL have parameter MIN_W, default 3, giving the minimum legal pulse width in clocks; shorter pulses are glitches.
REQ-003 The block SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port din  input  1  asynchronous level input, driven by the upstream AND-tree output.
REQ-006 The block SHALL have port meas_valid  output  1  a measurement result is held.
REQ-007 The block SHALL have port meas_ready  input  1  consumer accepts the result.
REQ-008 The block SHALL have port meas_width  output  CNT_W  measured high time in clocks.
REQ-009 The block SHALL have port meas_glitch  output  1  the held result has meas_width < MIN_W.
REQ-010 The block SHALL have port meas_sat  output  1  the width counter saturated during the pulse.
REQ-011 The block SHALL have port busy  output  1  the FSM is in MEASURE.

Function
REQ-012 din SHALL pass through a two-flop synchronizer (s1, s2); edge detection SHALL compare s2 with a registered copy, prev.
REQ-013 The FSM SHALL have states IDLE, MEASURE and HOLD.
REQ-014 IDLE: on the rising edge condition (s2=1, prev=0) the FSM SHALL go to MEASURE with count=1; otherwise it SHALL stay in IDLE.
REQ-015 MEASURE: while s2=1, count SHALL increment by 1 per clock and saturate at 2^CNT_W-1; reaching saturation SHALL set the sat flag.
REQ-016 MEASURE: on the falling edge condition (s2=0, prev=1) the FSM SHALL load meas_width=count, meas_glitch=(count<MIN_W) and meas_sat=sat, then go to HOLD.
REQ-017 Latency: if din is sampled high at edges k..k+N-1 and low at edge k+N, then meas_width=N and meas_valid SHALL rise after edge k+N+2.
REQ-018 HOLD: meas_valid=1, and meas_width, meas_glitch and meas_sat SHALL stay stable until the cycle in which meas_valid and meas_ready are both high.
REQ-019 HOLD, on handshake with no rising edge condition: the FSM SHALL go to IDLE and meas_valid SHALL be 0 in the next cycle.
REQ-020 HOLD, on handshake in the same cycle as a rising edge condition: the FSM SHALL go directly to MEASURE with count=1, and the pulse SHALL NOT be dropped.
REQ-021 HOLD, on a rising edge condition without handshake: the pulse SHALL be dropped and SHALL never be measured, even partially.
REQ-022 meas_ready while meas_valid=0 SHALL be ignored.
REQ-023 The count, sat and the result registers SHALL be CNT_W-bit unsigned with no wrap-around.

Reset
REQ-024 While reset=1 at a clock edge: state=IDLE, count=0, sat=0, meas_valid=0, meas_width=0, meas_glitch=0, meas_sat=0, busy=0.
REQ-025 s1, s2 and prev SHALL reset to 1, so a din level already high at reset release is never measured; a measurement requires din to be seen low first.
REQ-026 Reset in MEASURE or HOLD SHALL abort the measurement with no result and no handshake.

Configuration
REQ-027 With macro PULSE_WIDTH_METER_DROP_CNT_EN defined, the block SHALL add port drop_cnt  output  8.
REQ-028 drop_cnt SHALL count the pulses dropped per REQ-021, saturate at 255, and reset to 0.
REQ-029 Without PULSE_WIDTH_METER_DROP_CNT_EN, the drop_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 A bench SHALL cover: din high 5 clocks, meas_ready=1 -> meas_width=5, meas_glitch=0, meas_sat=0; meas_valid rises 2 clocks after din is first sampled low, for 1 cycle.
REQ-031 A bench SHALL cover: din high 2 clocks (MIN_W=3) -> meas_width=2, meas_glitch=1.
REQ-032 A bench SHALL cover: CNT_W=4, din high 20 clocks -> meas_width=15, meas_sat=1.
REQ-033 A bench SHALL cover: meas_ready=0, then pulses of 4 and 6 clocks -> result stays width 4, the second pulse is dropped, and drop_cnt=1 (macro on); raising meas_ready -> IDLE.
REQ-034 A bench SHALL cover: din already high at reset release for 10 clocks -> no meas_valid; then a 3-clock pulse -> meas_width=3.
REQ-035 A bench SHALL cover: reset asserted 2 clocks into a pulse -> all outputs 0, no result for that pulse.
